adc_conv_sequencer: RTL and testbench
=====================================

# adc_conv_sequencer

Digital initiator for the 12-bit SAR ADC controller (`sar_ctrl`): drives its `en`/`soc` inputs, consumes `eoc`/`data`, and buffers results in a small FIFO for the bus-side reader. It provides single-shot and continuous conversion, an enable-settle delay, a conversion timeout, and sticky overflow/timeout flags. It sits between the register/bus logic and `sar_ctrl`, in the `sar_ctrl` clock domain.

## Interface
- `SIZE`, 12: result width; must match `sar_ctrl` SIZE.
- `DEPTH`, 4: result FIFO entries; power of 2, at least 2.
- `SETTLE`, 8: cycles from `adc_en` rising to the first `soc` allowed.
- `TIMEOUT`, 64: maximum cycles in WAIT_EOC before abort.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `enable`  in  1  level; ADC subsystem enable request.
- `start`  in  1  one-cycle pulse; request one conversion (ignored unless IDLE).
- `cont`  in  1  level; continuous mode while high.
- `period`  in  16  continuous mode: idle cycles between CAPTURE and the next `soc`.
- `clr`  in  1  one-cycle pulse; flush FIFO, clear `overflow`/`timeout`.
- `adc_en`  out  1  to `sar_ctrl.en`.
- `soc`  out  1  to `sar_ctrl.soc`.
- `eoc`  in  1  from `sar_ctrl.eoc`.
- `data`  in  SIZE  from `sar_ctrl.data`; valid while `eoc` is high.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  SIZE  FIFO head (show-ahead).
- `rd_ready`  in  1  pop head when `rd_valid && rd_ready`.
- `busy`  out  1  high in any state other than IDLE/OFF.
- `overflow`  out  1  sticky: result dropped because FIFO full.
- `timeout`  out  1  sticky: `eoc` not seen within TIMEOUT.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Reset: state OFF; `adc_en`=0, `soc`=0, `busy`=0, `overflow`=0, `timeout`=0, `rd_valid`=0, `rd_data`=0, `level`=0; FIFO empty; counters 0.
- `adc_en` is the registered value of `enable`. It is 1 in every state except OFF.
- States and transitions:
  - OFF: `enable`=1 goes to SETTLE, with the counter loaded to SETTLE-1.
  - SETTLE: decrement each cycle; at 0 go to IDLE.
  - IDLE: a `start` pulse, or `cont`=1, goes to SOC.
  - SOC: `soc`=1 for exactly 1 cycle, then WAIT_EOC with the counter loaded to TIMEOUT-1.
  - WAIT_EOC: a rising edge of `eoc` (`eoc` high this cycle, low the previous cycle) goes to CAPTURE and registers `data` that cycle. Counter at 0 with no edge sets `timeout` and goes to IDLE.
  - CAPTURE: push the registered sample. Then, if `cont`=1 and `period`>0, go to HOLD with the counter loaded to `period`-1. If `cont`=1 and `period`=0, go to SOC. Otherwise go to IDLE.
  - HOLD: decrement; at 0 go to SOC if `cont`=1, else IDLE. `cont` falling mid-HOLD finishes at IDLE without a new `soc`.
- `enable`=0 in any state goes to OFF on the next cycle and drives `soc` to 0. An in-flight conversion is discarded, not pushed. FIFO contents and flags are kept.
- FIFO behaviour:
  - Push when full: the sample is dropped, `overflow` is set, and contents are unchanged.
  - Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted, `level` stays DEPTH, and `overflow` is not set.
  - Pop when empty: ignored.
  - Pointers wrap modulo DEPTH.
- `clr`:
  - Empties the FIFO and clears both flags the next cycle. A push in the same cycle is discarded.
  - If `clr` coincides with a flag-set event, the flag ends up set (set wins).
  - `clr` does not change the FSM state.
- `start` arriving outside IDLE is ignored, not queued.

## Timing
- `start` sampled high in IDLE (cycle 0) gives `soc`=1 in cycle 1 and WAIT_EOC from cycle 2.
- An `eoc` rising edge seen at cycle N gives the FIFO write at the end of cycle N+1. `rd_valid` goes high in cycle N+2 if the FIFO was empty.
- Continuous sample spacing is the `sar_ctrl` conversion time plus `period`+2 cycles.
- `enable` rising at cycle 0 gives `adc_en`=1 in cycle 1. The earliest possible `soc` is cycle SETTLE+2.
- A timeout sets `timeout` exactly TIMEOUT cycles after the first WAIT_EOC cycle.
- `rd_data` is stable while `rd_valid`=1 and `rd_ready`=0.

## Test plan
- Reset with `enable`=1 → `adc_en` rises 1 cycle later. Pulse `start` at cycle 20 → one 1-cycle `soc`. Model `eoc` with `data`=12'hA5C → `rd_valid`=1 and `rd_data`=12'hA5C; pop → `rd_valid`=0, `level`=0.
- `cont`=1, `period`=3, `rd_ready`=0, DEPTH=4 → 4 samples buffered. The 5th conversion sets `overflow` and FIFO holds the first 4 in order. Then `clr` → `level`=0, `overflow`=0.
- FIFO full with `rd_ready`=1 on the push cycle → push accepted, `level` stays 4, `overflow`=0, and order is preserved across pointer wrap.
- No `eoc` after `soc` → `timeout`=1 exactly 64 cycles into WAIT_EOC, FSM returns to IDLE, and a following `start` converts normally.
- Drop `enable` in WAIT_EOC, then let `eoc` rise → `soc`/`adc_en`=0 and no push. Re-enable → no `soc` before SETTLE+2 cycles.
- Assert `rst` asynchronously mid-HOLD with 2 entries stored → all outputs return to reset values immediately, FIFO empty.

Source files
------------

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: drives sar_ctrl en/soc, captures eoc/data results into a show-ahead FIFO.
// Latency: start -> soc 1 cycle; eoc rising edge -> FIFO write 1 cycle later, rd_valid the cycle after.
// Backpressure: none toward sar_ctrl; a full FIFO drops the sample and sets the sticky overflow flag.
module adc_conv_sequencer #(
  parameter int SIZE    = 12,
  parameter int DEPTH   = 4,
  parameter int SETTLE  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     cont,
  input  logic [15:0]              period,
  input  logic                     clr,
  output logic                     adc_en,
  output logic                     soc,
  input  logic                     eoc,
  input  logic [SIZE-1:0]          data,
  output logic                     rd_valid,
  output logic [SIZE-1:0]          rd_data,
  input  logic                     rd_ready,
  output logic                     busy,
  output logic                     overflow,
  output logic                     timeout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_OFF, S_SETTLE, S_IDLE, S_SOC, S_WAIT_EOC, S_CAPTURE, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              adc_en_q, eoc_q;
  logic [SIZE-1:0]   sample_q;
  logic              overflow_q, overflow_d, timeout_q, timeout_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [SIZE-1:0]   mem_q [DEPTH];

  logic eoc_rise, sample_en, push_req, to_set;
  logic full, pop, push_ok, ovf_set;

  assign eoc_rise = eoc && !eoc_q;

  // Next-state and counter logic; enable low overrides everything and parks in OFF
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sample_en = 1'b0;
    push_req  = 1'b0;
    to_set    = 1'b0;
    case (state_q)
      S_OFF: begin
        if (enable) begin
          state_d = S_SETTLE;
          cnt_d   = 16'(SETTLE - 1);
        end
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      S_IDLE: begin
        if (start || cont) state_d = S_SOC;
      end
      S_SOC: begin
        state_d = S_WAIT_EOC;
        cnt_d   = 16'(TIMEOUT - 1);
      end
      S_WAIT_EOC: begin
        if (eoc_rise) begin
          state_d   = S_CAPTURE;
          sample_en = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          to_set  = 1'b1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_CAPTURE: begin
        push_req = 1'b1;
        if (cont && (period != '0)) begin
          state_d = S_HOLD;
          cnt_d   = period - 16'd1;
        end else if (cont) begin
          state_d = S_SOC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = cont ? S_SOC : S_IDLE;
        else             cnt_d   = cnt_q - 16'd1;
      end
      default: state_d = S_OFF;
    endcase
    // Disabling discards any in-flight conversion: no push, no timeout
    if (!enable) begin
      state_d   = S_OFF;
      cnt_d     = '0;
      sample_en = 1'b0;
      push_req  = 1'b0;
      to_set    = 1'b0;
    end
  end

  // FIFO pointer/occupancy and sticky flag next-state; a pop frees the slot a same-cycle push needs
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    pop      = (count_q != '0) && rd_ready;
    push_ok  = push_req && (!full || pop);
    ovf_set  = push_req && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push_ok) count_d = count_q - 1'b1;
    end
    overflow_d = (overflow_q && !clr) || ovf_set;
    timeout_d  = (timeout_q && !clr) || to_set;
  end

  // Control state, counters, sample register and flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_OFF;
      cnt_q      <= '0;
      adc_en_q   <= 1'b0;
      eoc_q      <= 1'b0;
      sample_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      adc_en_q   <= enable;
      eoc_q      <= eoc;
      if (sample_en) sample_q <= data;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  // FIFO storage; entries are only observable through rd_data while occupied, so no reset
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem_q[wr_ptr_q] <= sample_q;
  end

  assign adc_en   = adc_en_q;
  assign soc      = (state_q == S_SOC);
  assign busy     = (state_q != S_OFF) && (state_q != S_IDLE);
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;
  assign level    = count_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer: cycle table for single-shot flow, then hand sequences
// for continuous/overflow, full push+pop with wrap, timeout, enable drop and async reset.
module tb_adc_conv_sequencer;

  logic        clk = 1'b0;
  logic        rst, enable, start, cont, clr, eoc, rd_ready;
  logic [15:0] period;
  logic [11:0] data;
  logic        adc_en, soc, rd_valid, busy, overflow, timeout;
  logic [11:0] rd_data;
  logic [2:0]  level;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  adc_conv_sequencer #(.SIZE(12), .DEPTH(4), .SETTLE(8), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .cont(cont),
    .period(period), .clr(clr), .adc_en(adc_en), .soc(soc), .eoc(eoc),
    .data(data), .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .busy(busy), .overflow(overflow), .timeout(timeout), .level(level)
  );

  typedef struct packed {
    logic        en, st, ct, eo;
    logic [11:0] dat;
    logic        rr, cl;
    int          n;
    logic [20:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic en, st, ct, eo, input logic [11:0] dat,
                              input logic rr, cl, input int n,
                              input logic aen, sc, bz, rv, input logic [11:0] rdat,
                              input logic [2:0] lvl, input logic ov, to);
    vec_t v;
    v.en = en; v.st = st; v.ct = ct; v.eo = eo; v.dat = dat;
    v.rr = rr; v.cl = cl; v.n = n;
    v.exp = {aen, sc, bz, rv, rdat, lvl, ov, to};
    return v;
  endfunction

  function automatic logic [20:0] outs();
    return {adc_en, soc, busy, rd_valid, rd_data, level, overflow, timeout};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Plays sar_ctrl: waits for soc, answers with an eoc rising edge 4 cycles later
  task automatic convert(input logic [11:0] d, input logic pop_on_push);
    for (int i = 0; i < 300 && !soc; i++) step();
    chk("soc_seen", {31'd0, soc}, 32'd1);
    step();
    repeat (3) step();
    eoc = 1'b1; data = d;
    step();
    rd_ready = pop_on_push;
    step();
    rd_ready = 1'b0; eoc = 1'b0; data = '0;
  endtask

  logic [11:0] wrap_exp [4];
  int found;

  initial begin
    rst = 1'b0; enable = 1'b1; start = 1'b0; cont = 1'b0; clr = 1'b0;
    eoc = 1'b0; rd_ready = 1'b0; period = 16'd0; data = '0;
    #2 rst = 1'b1;
    step(); step();
    chk("reset_state", {11'd0, outs()}, 32'd0);
    rst = 1'b0;

    //        en st ct eo dat     rr cl n    aen sc bz rv rdat    lvl ov to
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 7,  1, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 11, 1, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 0, 0, 1,  1, 1, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 12'h000, 0, 0, 1,  1, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 2,  1, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 12'hA5C, 0, 0, 1,  1, 0, 1, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 1,  1, 0, 0, 1, 12'hA5C, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 0, 3,  1, 0, 0, 1, 12'hA5C, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 1, 0, 1,  1, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 1, 0, 1,  1, 0, 0, 0, 12'h000, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 12'h000, 0, 1, 1,  1, 0, 0, 0, 12'h000, 0, 0, 0));

    foreach (vecs[i]) begin
      enable = vecs[i].en; start = vecs[i].st; cont = vecs[i].ct; eoc = vecs[i].eo;
      data = vecs[i].dat; rd_ready = vecs[i].rr; clr = vecs[i].cl;
      repeat (vecs[i].n) step();
      chk($sformatf("vec%0d", i), {11'd0, outs()}, {11'd0, vecs[i].exp});
    end
    start = 1'b0; rd_ready = 1'b0; clr = 1'b0; eoc = 1'b0; data = '0;

    // Continuous mode fills the FIFO, fifth result overflows
    cont = 1'b1; period = 16'd3;
    convert(12'h101, 1'b0);
    convert(12'h202, 1'b0);
    convert(12'h303, 1'b0);
    convert(12'h404, 1'b0);
    chk("cont_full_lvl", {31'd0, overflow} | {29'd0, level} << 4, 32'h40);
    convert(12'h505, 1'b0);
    chk("ovf_set", {19'd0, overflow, level, rd_data}, {19'd0, 1'b1, 3'd4, 12'h101});
    cont = 1'b0;
    repeat (6) step();
    chk("cont_stop_idle", {31'd0, busy}, 32'd0);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_flush", {27'd0, overflow, rd_valid, level}, 32'd0);

    // Full FIFO with pop on the push cycle; fifth entry lands in wrapped slot 0
    cont = 1'b1; period = 16'd3;
    convert(12'h011, 1'b0);
    convert(12'h022, 1'b0);
    convert(12'h033, 1'b0);
    convert(12'h044, 1'b0);
    convert(12'h055, 1'b1);
    chk("push_pop_full", {28'd0, overflow, level}, {28'd0, 1'b0, 3'd4});
    cont = 1'b0;
    repeat (4) step();
    wrap_exp[0] = 12'h022; wrap_exp[1] = 12'h033; wrap_exp[2] = 12'h044; wrap_exp[3] = 12'h055;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("wrap_head%0d", i), {19'd0, rd_valid, rd_data}, {19'd0, 1'b1, wrap_exp[i]});
      rd_ready = 1'b1; step(); rd_ready = 1'b0;
    end
    chk("wrap_empty", {28'd0, rd_valid, level}, 32'd0);

    // Timeout: flag appears exactly 64 cycles after the first WAIT_EOC cycle
    start = 1'b1; step(); start = 1'b0;
    step();
    repeat (63) step();
    chk("timeout_early", {30'd0, timeout, busy}, {30'd0, 1'b0, 1'b1});
    step();
    chk("timeout_hit", {30'd0, timeout, busy}, {30'd0, 1'b1, 1'b0});
    start = 1'b1; step(); start = 1'b0;
    convert(12'h7E1, 1'b0);
    chk("after_timeout", {18'd0, timeout, rd_valid, rd_data}, {18'd0, 1'b1, 1'b1, 12'h7E1});
    rd_ready = 1'b1; step(); rd_ready = 1'b0;

    // Enable drop mid-conversion discards the result
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    enable = 1'b0; step();
    chk("disable_outs", {29'd0, adc_en, soc, busy}, 32'd0);
    eoc = 1'b1; data = 12'h3C3; step(); step(); eoc = 1'b0; data = '0; step();
    chk("disable_nopush", {28'd0, rd_valid, level}, 32'd0);
    cont = 1'b1; enable = 1'b1;
    found = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (soc) begin
        found = i;
        break;
      end
    end
    chk("reenable_soc_cycle", found, 32'd10);
    cont = 1'b0;
    convert(12'h5A5, 1'b0);

    // Asynchronous reset mid-HOLD with two entries stored
    cont = 1'b1; period = 16'd20;
    convert(12'h6B6, 1'b0);
    chk("pre_reset_hold", {28'd0, busy, level}, {28'd0, 1'b1, 3'd2});
    repeat (3) step();
    rst = 1'b1;
    #2;
    chk("async_reset", {11'd0, outs()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
